pipelined_barrel_shifter: RTL

//  Parametrised, pipelined multi-function barrel shifter: SLL/SRL/SRA/ROL/ROR on a WIDTH-bit operand.

---
 rtl/shifter_pkg.sv | 26 ++
 rtl/pipelined_barrel_shifter_if.sv | 30 +++
 rtl/pipelined_barrel_shifter_shift_stage.sv | 17 +
 rtl/reverser.sv | 11 +
 rtl/pipelined_barrel_shifter.sv | 125 ++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared opcode type and op-class helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_t;

    // Left ops are executed as right ops on the bit-reversed operand.
    function automatic logic is_left(op_t op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic is_rot(op_t op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    // Codes 5..7 are reserved and behave as a passthrough.
    function automatic logic is_legal(op_t op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Request/response handshake bundle between issue stage, shifter and consumer.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    import shifter_pkg::*;
    localparam int LOG2W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_num;
    logic [LOG2W-1:0]   in_amt;
    op_t                in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_num;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;

    modport master (
        output in_valid, in_num, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_num, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_num, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_num, out_tag, out_zero
    );
endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One right-shift stage of fixed distance SH; vacated top bits come from
// the bits shifted out (rotate) or from the fill bit (logical/arith).
module shift_stage #(
    parameter int WIDTH = 32,
    parameter int SH    = 1
) (
    input  logic [WIDTH-1:0] i_num,
    input  logic             i_en,
    input  logic             i_rot,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_num
);
    logic [SH-1:0] w_top;

    assign w_top = i_rot ? i_num[SH-1:0] : {SH{i_fill}};
    assign o_num = i_en ? {w_top, i_num[WIDTH-1:SH]} : i_num;
endmodule

// File: rtl/reverser.sv
// Bit-order reverser, used to turn left shifts/rotates into right ones.
module reverser #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_d
);
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign o_d[i] = i_d[N-1-i];
    end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROL/ROR barrel shifter with valid/ready flow control.
// A register follows every REG_EVERY mux stages; the last one is the output.
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input logic                     clk,
    input logic                     rst,
    pipelined_barrel_shifter_if.slave bus
);
    import shifter_pkg::*;
    localparam int LOG2W = $clog2(WIDTH);

    // w_*[g] is what feeds mux stage g (register output or previous stage).
    logic               w_vld  [LOG2W];
    logic [WIDTH-1:0]   w_num  [LOG2W];
    logic [LOG2W-1:0]   w_amt  [LOG2W];
    op_t                w_op   [LOG2W];
    logic               w_fill [LOG2W];
    logic [TAG_W-1:0]   w_tag  [LOG2W];
    logic [WIDTH-1:0]   w_sh   [LOG2W];

    logic               w_adv;
    logic [WIDTH-1:0]   w_in_rev;
    logic [WIDTH-1:0]   w_out_rev;
    logic [WIDTH-1:0]   w_res;

    logic               r_out_vld;
    logic [WIDTH-1:0]   r_out_num;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_zero;

    // Whole pipe moves together; bubbles are kept, not squeezed out.
    assign w_adv        = !r_out_vld || bus.out_ready;
    assign bus.in_ready = w_adv;

    reverser #(.N(WIDTH)) u_rev_in (.i_d(bus.in_num), .o_d(w_in_rev));

    // Reserved ops get amt forced to 0 so every stage passes through.
    assign w_vld[0]  = bus.in_valid && w_adv;
    assign w_num[0]  = is_left(bus.in_op) ? w_in_rev : bus.in_num;
    assign w_amt[0]  = is_legal(bus.in_op) ? bus.in_amt : '0;
    assign w_op[0]   = bus.in_op;
    assign w_fill[0] = (bus.in_op == OP_SRA) && bus.in_num[WIDTH-1];
    assign w_tag[0]  = bus.in_tag;

    for (genvar g = 0; g < LOG2W; g++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH), .SH(1 << g)) u_stage (
            .i_num  (w_num[g]),
            .i_en   (w_amt[g][g]),
            .i_rot  (is_rot(w_op[g])),
            .i_fill (w_fill[g]),
            .o_num  (w_sh[g])
        );

        if (g < LOG2W - 1) begin : g_link
            if ((g + 1) % REG_EVERY == 0) begin : g_reg
                logic             r_vld;
                logic [WIDTH-1:0] r_num;
                logic [LOG2W-1:0] r_amt;
                op_t              r_op;
                logic             r_fill;
                logic [TAG_W-1:0] r_tag;

                // Intermediate pipeline register: load on advance, hold on stall.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_vld  <= 1'b0;
                        r_num  <= '0;
                        r_amt  <= '0;
                        r_op   <= OP_SLL;
                        r_fill <= 1'b0;
                        r_tag  <= '0;
                    end else if (w_adv) begin
                        r_vld  <= w_vld[g];
                        r_num  <= w_sh[g];
                        r_amt  <= w_amt[g];
                        r_op   <= w_op[g];
                        r_fill <= w_fill[g];
                        r_tag  <= w_tag[g];
                    end
                end

                assign w_vld[g+1]  = r_vld;
                assign w_num[g+1]  = r_num;
                assign w_amt[g+1]  = r_amt;
                assign w_op[g+1]   = r_op;
                assign w_fill[g+1] = r_fill;
                assign w_tag[g+1]  = r_tag;
            end else begin : g_comb
                assign w_vld[g+1]  = w_vld[g];
                assign w_num[g+1]  = w_sh[g];
                assign w_amt[g+1]  = w_amt[g];
                assign w_op[g+1]   = w_op[g];
                assign w_fill[g+1] = w_fill[g];
                assign w_tag[g+1]  = w_tag[g];
            end
        end
    end

    reverser #(.N(WIDTH)) u_rev_out (.i_d(w_sh[LOG2W-1]), .o_d(w_out_rev));

    assign w_res = is_left(w_op[LOG2W-1]) ? w_out_rev : w_sh[LOG2W-1];

    // Output register; zero flag is derived from the final result in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_num  <= '0;
            r_out_tag  <= '0;
            r_out_zero <= 1'b0;
        end else if (w_adv) begin
            r_out_vld  <= w_vld[LOG2W-1];
            r_out_num  <= w_res;
            r_out_tag  <= w_tag[LOG2W-1];
            r_out_zero <= (w_res == '0);
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.out_num   = r_out_num;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_zero  = r_out_zero;
endmodule
